// File: rtl/lut_sweep_pkg.sv
// Shared types and helpers for the LUT sweep sequencer.
// State encoding, table geometry and the index-to-table-bit mapping.
package lut_sweep_pkg;

  localparam int N_IN = 3;
  localparam int TT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Vector i lands in table bit 7-i, so vector 000 ends up in the MSB.
  function automatic logic [N_IN-1:0] vec_bit(input logic [N_IN-1:0] idx);
    logic [N_IN-1:0] top;
    top = N_IN'(TT_W - 1);
    return top - idx;
  endfunction

endpackage

// File: rtl/lut_sweep_settle_cnt.sv
// Settle-time counter for the sweep sequencer: clear/enable with a flag
// that is high while the count equals SETTLE_CYCLES-1.
module lut_sweep_settle_cnt #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign term = (cnt_reg == LAST);

endmodule

// File: rtl/lut_sweep_sequencer.sv
// Sweeps a 3-input gate through all 8 vectors and returns its truth table.
// Optional output-stability check enabled by defining LUT_SWEEP_GLITCH_CHECK_EN.
module lut_sweep_sequencer
  import lut_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [TT_W-1:0] rule_exp,
  output logic            busy,
  output logic            in1,
  output logic            in2,
  output logic            in3,
  input  logic            dut_out,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [TT_W-1:0] res_tt,
  output logic            res_match,
  output logic            res_unstable
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETTLE = SETTLE;
  localparam logic [1:0] ST_SAMPLE = SAMPLE;
  localparam logic [1:0] ST_DONE   = DONE;
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("lut_sweep_sequencer: SETTLE_CYCLES must be in 1..255");
    end
    if (CNT_W < 1 || CNT_W > 30 || SETTLE_CYCLES >= (1 << CNT_W)) begin : g_bad_cnt_w
      $error("lut_sweep_sequencer: CNT_W too narrow for SETTLE_CYCLES");
    end
  endgenerate

  logic [1:0]      state_reg;
  logic [N_IN-1:0] idx_reg;
  logic [TT_W-1:0] tt_reg;
  logic [TT_W-1:0] exp_reg;
  logic            busy_reg;
  logic            valid_reg;
  logic            match_reg;

  logic            accept;
  logic            settle_term;
  logic [TT_W-1:0] tt_next;

  always_comb begin
    accept  = (state_reg == ST_IDLE) && start;
    tt_next = tt_reg;
    tt_next[vec_bit(idx_reg)] = dut_out;
  end

  lut_sweep_settle_cnt #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_settle_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept || ((state_reg == ST_SETTLE) && settle_term)),
    .en   (state_reg == ST_SETTLE),
    .term (settle_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      tt_reg    <= '0;
      exp_reg   <= '0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      match_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_SETTLE;
            idx_reg   <= '0;
            tt_reg    <= '0;
            exp_reg   <= rule_exp;
            busy_reg  <= 1'b1;
            match_reg <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_term) begin
            state_reg <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          tt_reg <= tt_next;
          if (idx_reg == IDX_LAST) begin
            state_reg <= ST_DONE;
            valid_reg <= 1'b1;
            match_reg <= (tt_next == exp_reg);
          end else begin
            idx_reg   <= idx_reg + N_IN'(1);
            state_reg <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          // The vector is left at 111 after the handshake until the next sweep.
          if (res_ready) begin
            state_reg <= ST_IDLE;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef LUT_SWEEP_GLITCH_CHECK_EN
  logic last_reg;
  logic unstable_reg;

  // Reference value is the output seen on the last settle cycle of each vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg     <= 1'b0;
      unstable_reg <= 1'b0;
    end else begin
      if ((state_reg == ST_SETTLE) && settle_term) begin
        last_reg <= dut_out;
      end
      if (accept) begin
        unstable_reg <= 1'b0;
      end else if ((state_reg == ST_SAMPLE) && (dut_out != last_reg)) begin
        unstable_reg <= 1'b1;
      end
    end
  end

  assign res_unstable = unstable_reg && (state_reg == ST_DONE);
`else
  assign res_unstable = 1'b0;
`endif

  assign busy      = busy_reg;
  assign in1       = idx_reg[2];
  assign in2       = idx_reg[1];
  assign in3       = idx_reg[0];
  assign res_valid = valid_reg;
  assign res_tt    = tt_reg;
  assign res_match = match_reg;

endmodule

// File: tb/tb_lut_sweep_sequencer.sv
// Directed bench for lut_sweep_sequencer driving a rule-0x63 gate model;
// expectations for res_unstable follow LUT_SWEEP_GLITCH_CHECK_EN.
module tb_lut_sweep_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rule_exp = 8'h00;
  logic       res_ready = 1'b0;
  logic       busy, in1, in2, in3, dut_out, res_valid, res_match, res_unstable;
  logic [7:0] res_tt;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] model_rule = 8'h63;
  bit         glitch_en = 1'b0;
  logic [2:0] vec;
  logic [2:0] bitpos;
  logic [2:0] last_vec = 3'd0;
  int         hold = 0;
  logic       exp_unst;

  always #5 clk = ~clk;

  assign vec    = {in1, in2, in3};
  assign bitpos = 3'd7 - vec;
  // Gate model; optionally flips its output during the sample cycle of vector 5.
  assign dut_out = model_rule[bitpos] ^ (glitch_en && (vec == 3'd5) && (hold == 4));

  always @(negedge clk) begin
    if (vec != last_vec) hold <= 0;
    else hold <= hold + 1;
    last_vec <= vec;
  end

  lut_sweep_sequencer #(
    .SETTLE_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rule_exp     (rule_exp),
    .busy         (busy),
    .in1          (in1),
    .in2          (in2),
    .in3          (in3),
    .dut_out      (dut_out),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_tt       (res_tt),
    .res_match    (res_match),
    .res_unstable (res_unstable)
  );

  // Starts a sweep and waits (bounded) for res_valid; rule_exp is scrambled after acceptance.
  task automatic do_sweep(input logic [7:0] rule, input bit keep_start,
                          output int cycles, output bit seq_ok);
    @(negedge clk);
    rule_exp = rule;
    start    = 1'b1;
    @(posedge clk); #1;
    if (!keep_start) start = 1'b0;
    rule_exp = ~rule;
    cycles   = 0;
    seq_ok   = 1'b1;
    while (cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles < 40 && vec != 3'(cycles / 5)) seq_ok = 1'b0;
      if (res_valid) break;
    end
    $display("sweep rule=%h res_tt=%h res_match=%b res_unstable=%b cycles=%0d seq_ok=%b",
             rule, res_tt, res_match, res_unstable, cycles, seq_ok);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, res_valid, res_match, res_unstable, vec, res_tt} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %b want all zero",
               {busy, res_valid, res_match, res_unstable, vec, res_tt});
    end
    @(negedge clk);
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_sweep_match;
    int c; bit ok;
    do_sweep(8'h63, 1'b0, c, ok);
    vectors++;
    if (c !== 40) begin miscompares++; $display("FAIL match_latency: got %0d want 40", c); end
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL match_vec_order: got %b want 1", ok); end
    vectors++;
    if ({busy, vec, res_tt, res_match, res_unstable} !== {1'b1, 3'd7, 8'h63, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL match_result: got busy=%b vec=%b tt=%h match=%b unst=%b want 1 111 63 1 0",
               busy, vec, res_tt, res_match, res_unstable);
    end
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    vectors++;
    if ({busy, res_valid, vec} !== {1'b0, 1'b0, 3'd7}) begin
      miscompares++;
      $display("FAIL match_handshake: got busy=%b valid=%b vec=%b want 0 0 111", busy, res_valid, vec);
    end
  endtask

  task automatic test_sweep_mismatch;
    int c; bit ok;
    do_sweep(8'h96, 1'b0, c, ok);
    vectors++;
    if ({c == 40, res_tt, res_match} !== {1'b1, 8'h63, 1'b0}) begin
      miscompares++;
      $display("FAIL mismatch_result: got cycles=%0d tt=%h match=%b want 40 63 0", c, res_tt, res_match);
    end
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
  endtask

  task automatic test_result_hold;
    int c; bit ok;
    do_sweep(8'h63, 1'b0, c, ok);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i == 3);
      @(posedge clk); #1;
      vectors++;
      if ({res_valid, busy, vec, res_tt, res_match} !== {1'b1, 1'b1, 3'd7, 8'h63, 1'b1}) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: got valid=%b busy=%b vec=%b tt=%h match=%b want 1 1 111 63 1",
                 i, res_valid, busy, vec, res_tt, res_match);
      end
    end
    @(negedge clk); start = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, res_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL hold_release: got busy=%b valid=%b want 0 0", busy, res_valid);
    end
    @(negedge clk); start = 1'b0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_start_not_queued: got busy=%b want 0", busy);
    end
    $display("result hold and release done");
  endtask

  task automatic test_reset_mid;
    int c; int n; bit ok;
    @(negedge clk); rule_exp = 8'h63; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (vec != 3'd3 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (vec !== 3'd3) begin miscompares++; $display("FAIL rstmid_reach_vec3: got %b want 011", vec); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, res_valid, res_match, res_unstable, vec, res_tt} !== 15'd0) begin
      miscompares++;
      $display("FAIL rstmid_state: got %b want all zero",
               {busy, res_valid, res_match, res_unstable, vec, res_tt});
    end
    @(negedge clk); rst = 1'b0;
    do_sweep(8'h63, 1'b0, c, ok);
    vectors++;
    if ({c == 40, ok, res_tt, res_match} !== {1'b1, 1'b1, 8'h63, 1'b1}) begin
      miscompares++;
      $display("FAIL rstmid_resweep: got cycles=%0d seq=%b tt=%h match=%b want 40 1 63 1",
               c, ok, res_tt, res_match);
    end
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int c; bit ok;
    do_sweep(8'h63, 1'b1, c, ok);
    vectors++;
    if ({c == 40, ok, res_tt, res_match} !== {1'b1, 1'b1, 8'h63, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_first: got cycles=%0d seq=%b tt=%h match=%b want 40 1 63 1",
               c, ok, res_tt, res_match);
    end
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_gap: got busy=%b want 0", busy); end
    do_sweep(8'h96, 1'b1, c, ok);
    vectors++;
    if ({c == 40, ok, res_tt, res_match} !== {1'b1, 1'b1, 8'h63, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_second: got cycles=%0d seq=%b tt=%h match=%b want 40 1 63 0",
               c, ok, res_tt, res_match);
    end
    start = 1'b0;
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({busy, res_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_end: got busy=%b valid=%b want 0 0", busy, res_valid);
    end
  endtask

  task automatic test_glitch;
    int c; bit ok;
`ifdef LUT_SWEEP_GLITCH_CHECK_EN
    exp_unst = 1'b1;
`else
    exp_unst = 1'b0;
`endif
    glitch_en = 1'b1;
    do_sweep(8'h63, 1'b0, c, ok);
    glitch_en = 1'b0;
    vectors++;
    if ({c == 40, res_tt, res_match, res_unstable} !== {1'b1, 8'h67, 1'b0, exp_unst}) begin
      miscompares++;
      $display("FAIL glitch_flag: got cycles=%0d tt=%h match=%b unst=%b want 40 67 0 %b",
               c, res_tt, res_match, res_unstable, exp_unst);
    end
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    vectors++;
    if (res_unstable !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_idle_hidden: got %b want 0", res_unstable);
    end
    do_sweep(8'h63, 1'b0, c, ok);
    vectors++;
    if ({res_tt, res_match, res_unstable} !== {8'h63, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL glitch_cleared: got tt=%h match=%b unst=%b want 63 1 0",
               res_tt, res_match, res_unstable);
    end
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep_match();
    test_sweep_mismatch();
    test_result_hold();
    test_reset_mid();
    test_back_to_back();
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
